mp3_track_ctrl: RTL and testbench

//  Upstream control stage for MP3_Driver; owns its play and mus_id inputs.

---
 rtl/mp3_track_ctrl_if.sv | 13 +
 rtl/mp3_track_ctrl.sv | 139 +++++++++++++
 tb/tb_mp3_track_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mp3_track_ctrl_if.sv
// Event/track bus between game/UI logic and the track controller.
// The controller takes the slave side; whoever raises the events takes the master side.
`timescale 1ns/1ps
interface mp3_track_ctrl_if;
  logic       I_next;
  logic       I_mute;
  logic       I_evt_win;
  logic       play;
  logic [1:0] mus_id;

  modport master (output I_next, I_mute, I_evt_win, input play, mus_id);
  modport slave  (input I_next, I_mute, I_evt_win, output play, mus_id);
endinterface

// File: rtl/mp3_track_ctrl.sv
// Track selection for MP3_Driver: background rotation, win jingle, mute, with a play-low gap on every change.
// Optional feature macro: MP3_TRACK_AUTO_ADVANCE_EN (periodic background auto-advance).
`timescale 1ns/1ps
module mp3_track_ctrl #(
  parameter int         GAP_CYCLES      = 2000,
  parameter int         JINGLE_CYCLES   = 6000000,
  parameter int         DEBOUNCE_CYCLES = 20000,
  parameter logic [1:0] BG_TRACK        = 2'd0,
  parameter int         BG_CYCLES       = 120000000
) (
  input logic              R_clk_2M,
  input logic              I_rst,
  mp3_track_ctrl_if.slave  bus
);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int JW = $clog2(JINGLE_CYCLES + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [JW-1:0] JNG_LAST = JW'(JINGLE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]    WIN_TRACK = 2'd3;

  typedef enum logic [1:0] {MUTE, GAP, BG, JINGLE} state_t;

  function automatic logic [1:0] bg_inc(input logic [1:0] t);
    return (t == 2'd2) ? 2'd0 : t + 2'd1;
  endfunction

  // Debounce: level follows the synchronised input only after a full stable window
  logic [1:0]    sync;
  logic          deb_level, next_evt;
  logic [DW-1:0] deb_cnt;

  always_ff @(posedge R_clk_2M) begin
    if (I_rst) begin
      sync      <= '0;
      deb_level <= 1'b0;
      deb_cnt   <= '0;
      next_evt  <= 1'b0;
    end else begin
      sync     <= {sync[0], bus.I_next};
      next_evt <= 1'b0;
      if (sync[1] == deb_level) deb_cnt <= '0;
      else if (deb_cnt == DEB_LAST) begin
        deb_cnt   <= '0;
        deb_level <= sync[1];
        next_evt  <= sync[1];
      end else deb_cnt <= deb_cnt + 1'b1;
    end
  end

  state_t        state, state_n;
  logic [1:0]    target, target_n, bg_track, bg_n, mus_id, mus_n, gap_tgt;
  logic [GW-1:0] gap_cnt, gap_n;
  logic [JW-1:0] jng_cnt, jng_n;
  logic          play, play_n, adv, start_gap, auto_fire;

`ifdef MP3_TRACK_AUTO_ADVANCE_EN
  localparam int BW = $clog2(BG_CYCLES + 1);
  localparam logic [BW-1:0] BG_LAST = BW'(BG_CYCLES - 1);
  logic [BW-1:0] bg_cnt;

  // Held at zero outside BG so it restarts on every BG entry
  always_ff @(posedge R_clk_2M) begin
    if (I_rst || state != BG || auto_fire) bg_cnt <= '0;
    else                                   bg_cnt <= bg_cnt + 1'b1;
  end
  assign auto_fire = (state == BG) && (bg_cnt == BG_LAST);
`else
  assign auto_fire = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    target_n  = target;
    gap_n     = gap_cnt;
    jng_n     = jng_cnt;
    play_n    = play;
    mus_n     = mus_id;
    adv       = next_evt | (auto_fire & ~bus.I_mute & ~bus.I_evt_win);
    bg_n      = adv ? bg_inc(bg_track) : bg_track;
    start_gap = 1'b0;
    gap_tgt   = bg_n;
    if (bus.I_mute) begin
      state_n = MUTE;
      play_n  = 1'b0;
    end else if (bus.I_evt_win && (state == BG || state == GAP)) begin
      start_gap = 1'b1;
      gap_tgt   = WIN_TRACK;
    end else begin
      case (state)
        MUTE:    start_gap = 1'b1;
        GAP:
          if (adv && target != WIN_TRACK) start_gap = 1'b1;
          else if (gap_cnt == GAP_LAST) begin
            play_n  = 1'b1;
            state_n = (target == WIN_TRACK) ? JINGLE : BG;
            jng_n   = '0;
          end else gap_n = gap_cnt + 1'b1;
        BG:      start_gap = adv;
        JINGLE:
          if (jng_cnt == JNG_LAST) start_gap = 1'b1;
          else                     jng_n = jng_cnt + 1'b1;
        default: start_gap = 1'b1;
      endcase
    end
    // mus_id only moves together with play dropping, so it is stable while playing
    if (start_gap) begin
      state_n  = GAP;
      target_n = gap_tgt;
      mus_n    = gap_tgt;
      gap_n    = '0;
      play_n   = 1'b0;
    end
  end

  always_ff @(posedge R_clk_2M) begin
    if (I_rst) begin
      state    <= GAP;
      target   <= BG_TRACK;
      bg_track <= BG_TRACK;
      mus_id   <= BG_TRACK;
      play     <= 1'b0;
      gap_cnt  <= '0;
      jng_cnt  <= '0;
    end else begin
      state    <= state_n;
      target   <= target_n;
      bg_track <= bg_n;
      mus_id   <= mus_n;
      play     <= play_n;
      gap_cnt  <= gap_n;
      jng_cnt  <= jng_n;
    end
  end

  assign bus.play   = play;
  assign bus.mus_id = mus_id;
endmodule

// File: tb/tb_mp3_track_ctrl.sv
// Directed bench for mp3_track_ctrl with short gap/jingle/debounce timings.
`timescale 1ns/1ps
module tb_mp3_track_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  mp3_track_ctrl_if bus();

  mp3_track_ctrl #(
    .GAP_CYCLES(4), .JINGLE_CYCLES(20), .DEBOUNCE_CYCLES(3),
    .BG_TRACK(2'd0), .BG_CYCLES(10)
  ) dut (
    .R_clk_2M(clk), .I_rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int low_run = 0, last_gap = 0, high_run = 0, last_high = 0, n_fall = 0, stab_err = 0;
  logic       prev_play = 1'b0;
  logic [1:0] prev_mus = 2'd0;

  // Output monitor: gap / play-high run lengths, play falls, mus_id stability while playing
  always @(negedge clk) begin
    if (rst) begin
      low_run   <= 0;
      high_run  <= 0;
      prev_play <= 1'b0;
    end else if (bus.play) begin
      high_run <= high_run + 1;
      low_run  <= 0;
      if (!prev_play) last_gap <= low_run;
      else if (bus.mus_id != prev_mus) stab_err <= stab_err + 1;
      prev_play <= 1'b1;
    end else begin
      low_run  <= low_run + 1;
      high_run <= 0;
      if (prev_play) begin
        last_high <= high_run;
        n_fall    <= n_fall + 1;
      end
      prev_play <= 1'b0;
    end
    prev_mus <= bus.mus_id;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press();
    bus.I_next = 1'b1;
    repeat (6) tick();
    bus.I_next = 1'b0;
    repeat (14) tick();
  endtask

  task automatic win_pulse();
    bus.I_evt_win = 1'b1;
    tick();
    bus.I_evt_win = 1'b0;
  endtask

  task automatic wait_play(input logic lvl, input string tag);
    for (int i = 0; i < 60 && bus.play !== lvl; i++) tick();
    chk(tag, int'(bus.play), int'(lvl));
  endtask

  task automatic count_to_play(output int n);
    n = 0;
    while (!bus.play && n < 60) begin
      tick();
      n++;
    end
  endtask

  int n, n0;
  int exp3[5] = '{2, 0, 1, 2, 0};

  initial begin
    bus.I_next = 1'b0; bus.I_mute = 1'b0; bus.I_evt_win = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_play", int'(bus.play), 0);
    chk("rst_mus", int'(bus.mus_id), 0);

    // Startup gap
    rst = 1'b0;
    count_to_play(n);
    chk("t1_gap", n, 4);
    chk("t1_mus", int'(bus.mus_id), 0);

    // One debounced press, then a too-short glitch
    n0 = n_fall;
    press();
    chk("t2_events", n_fall - n0, 1);
    chk("t2_mus", int'(bus.mus_id), 1);
    chk("t2_play", int'(bus.play), 1);
    chk("t2_gap", last_gap, 4);
    n0 = n_fall;
    bus.I_next = 1'b1;
    repeat (2) tick();
    bus.I_next = 1'b0;
    repeat (15) tick();
    chk("t2_glitch", n_fall - n0, 0);
    chk("t2_glitch_mus", int'(bus.mus_id), 1);

    // Rotation 1->2->0, then the walk 1,2,0 from track 0
    for (int i = 0; i < 5; i++) begin
      press();
      chk($sformatf("t3_mus%0d", i), int'(bus.mus_id), exp3[i]);
      chk($sformatf("t3_gap%0d", i), last_gap, 4);
      chk($sformatf("t3_play%0d", i), int'(bus.play), 1);
    end
    chk("t3_stable", stab_err, 0);

    // Win jingle from track 1, with a second win ignored mid-jingle
    press();
    chk("t4_bg1", int'(bus.mus_id), 1);
    win_pulse();
    chk("t4_play0", int'(bus.play), 0);
    chk("t4_mus3", int'(bus.mus_id), 3);
    wait_play(1'b1, "t4_jng_start");
    tick();
    chk("t4_gap", last_gap, 4);
    repeat (5) tick();
    win_pulse();
    chk("t4_rewin_play", int'(bus.play), 1);
    chk("t4_rewin_mus", int'(bus.mus_id), 3);
    wait_play(1'b0, "t4_jng_end");
    wait_play(1'b1, "t4_bg_resume");
    tick();
    chk("t4_jng_len", last_high, 20);
    chk("t4_gap2", last_gap, 4);
    chk("t4_mus_back", int'(bus.mus_id), 1);

    // Mute during jingle; a press while muted still advances the background
    win_pulse();
    wait_play(1'b1, "t5_jng_start");
    repeat (3) tick();
    bus.I_mute = 1'b1;
    tick();
    chk("t5_mute_play", int'(bus.play), 0);
    press();
    chk("t5_muted", int'(bus.play), 0);
    bus.I_mute = 1'b0;
    count_to_play(n);
    chk("t5_unmute_gap", n, 5);
    chk("t5_mus", int'(bus.mus_id), 2);

    // Reset mid-gap with the jingle targeted
    win_pulse();
    chk("t6_mus3", int'(bus.mus_id), 3);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("t6_rst_play", int'(bus.play), 0);
    chk("t6_rst_mus", int'(bus.mus_id), 0);
    rst = 1'b0;
    count_to_play(n);
    chk("t6_gap", n, 4);
    chk("t6_mus", int'(bus.mus_id), 0);

    // Without auto-advance, BG holds indefinitely
    n0 = n_fall;
    repeat (40) tick();
    chk("bg_hold", n_fall - n0, 0);
    chk("bg_hold_play", int'(bus.play), 1);
    chk("stable_final", stab_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
